addsub_pipe: RTL and testbench
==============================

# addsub_pipe

Parametrised, pipelined N-bit adder/subtractor with carry-in, carry-out and signed overflow. It is the successor to the fixed-width combinational ripple adder built from full-adder cells. The carry chain is split into STAGES equal slices with a registered carry between slices, so wide operands close timing on the iCE40 fabric. A valid flag travels alongside the data, and a global clock enable stalls the whole pipe. It sits between operand-producing logic and any downstream consumer that needs a registered sum.

## Interface
- WIDTH, 8: operand/result width in bits; must be ≥1 and divisible by STAGES.
- STAGES, 2: number of pipeline slices, which is also the latency in enabled cycles; 1 ≤ STAGES ≤ WIDTH.
- CLKIN  input  1  sole clock, rising-edge.
- RESET  input  1  synchronous, active-high reset; overrides CE.
- CE  input  1  clock enable; 0 freezes every register in the block.
- VALID  input  1  marks the operand set on I0/I1/SUB/CIN as a real operation.
- SUB  input  1  0: add; 1: subtract (I1 is bitwise inverted before the carry chain).
- I0  input  WIDTH  operand A.
- I1  input  WIDTH  operand B.
- CIN  input  1  carry into bit 0.
- O  output  WIDTH  registered result.
- COUT  output  1  carry out of bit WIDTH-1.
- V  output  1  signed overflow.
- VALIDOUT  output  1  O/COUT/V hold the result of a VALID operation.

## Operation
- Arithmetic: {COUT,O} = I0 + (SUB ? ~I1 : I1) + CIN, computed modulo 2^(WIDTH+1).
  - Subtraction is SUB=1, CIN=1.
  - With SUB=1, COUT=1 means no borrow.
  - SUB=1, CIN=0 yields I0 - I1 - 1.
- V = carry into bit WIDTH-1 XOR COUT, i.e. two's-complement overflow of the selected operation.
- Slice width is SW = WIDTH/STAGES. Slice k covers bits [k*SW +: SW].
- Stage k adds slice k with a LUT + carry-chain ripple, taking its carry-in from the stage k-1 carry register. Stage 0 takes CIN.
- Operand skew: slice k operands (with SUB already applied) are delayed k cycles before entering stage k.
- Result deskew: slice k result is delayed STAGES-1-k cycles, so all slices of one operation emerge together.
- VALID is delayed STAGES cycles to form VALIDOUT.
- Data registers are advanced regardless of VALID. Only VALIDOUT distinguishes real results; O/COUT/V for VALID=0 slots are don't-care but deterministic.
- No backpressure: a new operation may be presented on every enabled cycle.

## Timing
- Latency: an operation sampled at enabled edge n appears on O/COUT/V/VALIDOUT after enabled edge n+STAGES-1 and is stable until the next enabled edge. Throughput: 1 operation per enabled cycle.
- STAGES=1: single registered adder; result visible after the sampling edge itself.
- CE=0: no register changes. Outputs hold, and in-flight operations neither advance nor are lost. Inputs are ignored that cycle.
- RESET=1 at an edge clears every register, regardless of CE.
  - All pipeline data, carries, O, COUT, V and VALIDOUT become 0.
  - Operations in flight are discarded; no stale result ever emerges.
  - The first operation after RESET deasserts is sampled on the first enabled edge with RESET=0.
- Reset values: O=0, COUT=0, V=0, VALIDOUT=0.
- Wrap-around: the result is modulo 2^WIDTH, with the carry reported only on COUT. No saturation.

## Test plan
- WIDTH=8, STAGES=2: 0x7F + 0x01, CIN=0, SUB=0 → two enabled cycles later O=0x80, COUT=0, V=1, VALIDOUT=1.
- SUB=1, CIN=1: 0x05 - 0x07 → O=0xFE, COUT=0, V=0. Then 0x80 - 0x01 → O=0x7F, COUT=1, V=1.
- Slice-boundary carry: 0x0F + 0x01 → O=0x10. 0xFF + 0x01 → O=0x00, COUT=1, V=0. 0xFF + 0x00 with CIN=1 → O=0x00, COUT=1.
- Back-to-back stream of 4 VALID ops (1+2, 3+4, 0xF0+0x10, 0x80+0x80) → O = 0x03, 0x07, 0x00, 0x00 on consecutive cycles, with COUT=0,0,1,1 and V=0,0,0,1. A VALID=0 bubble inserted mid-stream gives exactly one VALIDOUT=0 cycle.
- CE held low 3 cycles with 2 ops in flight → outputs frozen. After CE returns, the remaining results appear in order with none lost or duplicated.
- RESET pulsed for 1 cycle with 2 ops in flight → the next cycle shows O=0, VALIDOUT=0, and no in-flight result appears afterwards. Repeat with WIDTH=16, STAGES=4 and 10k random ops against a behavioural model.

Source files
------------

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES slices
// with a registered carry between them, operands skewed in and results deskewed out.
module addsub_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             CLKIN,
  input  logic             RESET,
  input  logic             CE,
  input  logic             VALID,
  input  logic             SUB,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             CIN,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             V,
  output logic             VALIDOUT
);

  localparam int SW = WIDTH / STAGES;

  // [k][d]: slice k, delay tap d. Only taps d < k (skew) and d <= STAGES-1-k (deskew) are live.
  logic [SW-1:0]     a_sk_q  [STAGES][STAGES];
  logic [SW-1:0]     b_sk_q  [STAGES][STAGES];
  logic [SW-1:0]     res_q   [STAGES][STAGES];
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] valid_q;
  logic              v_q;

  logic [WIDTH-1:0]  b_eff;
  logic [SW-1:0]     op_a    [STAGES];
  logic [SW-1:0]     op_b    [STAGES];
  logic [SW:0]       sum_ext [STAGES];
  logic [SW-1:0]     sum_d   [STAGES];
  logic [STAGES-1:0] cin_d;
  logic [STAGES-1:0] carry_d;
  logic              msb_cin_d;

  always_comb begin
    b_eff = SUB ? ~I1 : I1;
    for (int k = 0; k < STAGES; k++) begin
      op_a[k]    = (k == 0) ? I0[SW-1:0]    : a_sk_q[k][(k == 0) ? 0 : k-1];
      op_b[k]    = (k == 0) ? b_eff[SW-1:0] : b_sk_q[k][(k == 0) ? 0 : k-1];
      cin_d[k]   = (k == 0) ? CIN           : carry_q[(k == 0) ? 0 : k-1];
      sum_ext[k] = {1'b0, op_a[k]} + {1'b0, op_b[k]} + {{SW{1'b0}}, cin_d[k]};
      sum_d[k]   = sum_ext[k][SW-1:0];
      carry_d[k] = sum_ext[k][SW];
    end
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    msb_cin_d = sum_d[STAGES-1][SW-1] ^ op_a[STAGES-1][SW-1] ^ op_b[STAGES-1][SW-1];
  end

  // NOTE: every register, including the delay arrays, is reset so that no
  // operation in flight at RESET can surface afterwards.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      for (int k = 0; k < STAGES; k++) begin
        for (int d = 0; d < STAGES; d++) begin
          a_sk_q[k][d] <= '0;
          b_sk_q[k][d] <= '0;
          res_q[k][d]  <= '0;
        end
      end
      carry_q <= '0;
      valid_q <= '0;
      v_q     <= 1'b0;
    end else if (CE) begin
      // NOTE: non-blocking assignments let each tap read its neighbour's old value,
      // so the loops describe shift registers regardless of iteration order.
      for (int k = 0; k < STAGES; k++) begin
        for (int d = 0; d < STAGES; d++) begin
          if (d < k) begin
            a_sk_q[k][d] <= (d == 0) ? I0[k*SW +: SW]    : a_sk_q[k][(d == 0) ? 0 : d-1];
            b_sk_q[k][d] <= (d == 0) ? b_eff[k*SW +: SW] : b_sk_q[k][(d == 0) ? 0 : d-1];
          end
          if (d <= STAGES-1-k) begin
            res_q[k][d] <= (d == 0) ? sum_d[k] : res_q[k][(d == 0) ? 0 : d-1];
          end
        end
      end
      carry_q    <= carry_d;
      valid_q[0] <= VALID;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
      v_q <= msb_cin_d ^ carry_d[STAGES-1];
    end
  end

  // NOTE: O gets a full default before the slice loop so no latch is inferred.
  always_comb begin
    O = '0;
    for (int k = 0; k < STAGES; k++) begin
      O[k*SW +: SW] = res_q[k][STAGES-1-k];
    end
  end

  assign COUT     = carry_q[STAGES-1];
  assign V        = v_q;
  assign VALIDOUT = valid_q[STAGES-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed checks on an 8-bit/2-stage instance plus a random stream on a
// 16-bit/4-stage instance compared against an independent arithmetic model.
module tb_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, ce8, vld8, sub8, cin8;
  logic [7:0] a8, b8, o8;
  logic       cout8, v8, vo8;

  logic        rst16, ce16, vld16, sub16, cin16;
  logic [15:0] a16, b16, o16;
  logic        cout16, v16, vo16;

  int errors = 0;
  int checks = 0;

  addsub_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
    .CLKIN(clk), .RESET(rst8), .CE(ce8), .VALID(vld8), .SUB(sub8),
    .I0(a8), .I1(b8), .CIN(cin8),
    .O(o8), .COUT(cout8), .V(v8), .VALIDOUT(vo8)
  );

  addsub_pipe #(.WIDTH(16), .STAGES(4)) dut16 (
    .CLKIN(clk), .RESET(rst16), .CE(ce16), .VALID(vld16), .SUB(sub16),
    .I0(a16), .I1(b16), .CIN(cin16),
    .O(o16), .COUT(cout16), .V(v16), .VALIDOUT(vo16)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic vld, input logic sub, input logic [7:0] a,
                        input logic [7:0] b, input logic cin);
    vld8 = vld; sub8 = sub; a8 = a; b8 = b; cin8 = cin;
  endtask

  task automatic expect8(input string tag, input logic [7:0] eo, input logic ec,
                         input logic ev, input logic evld);
    check({tag, ".o"},     32'(o8),    32'(eo));
    check({tag, ".cout"},  32'(cout8), 32'(ec));
    check({tag, ".v"},     32'(v8),    32'(ev));
    check({tag, ".valid"}, 32'(vo8),   32'(evld));
  endtask

  // Single op on the 2-stage pipe: sampled at one edge, visible after the next.
  task automatic single8(input string tag, input logic sub, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic [7:0] eo,
                         input logic ec, input logic ev);
    drive8(1'b1, sub, a, b, cin);
    step();
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step();
    expect8(tag, eo, ec, ev, 1'b1);
  endtask

  logic [15:0] m_o   [4];
  logic        m_c   [4];
  logic        m_v   [4];
  logic        m_vld [4];

  initial begin
    logic [16:0] full;
    logic [15:0] bb;
    int          ops;

    rst8 = 1'b1; ce8 = 1'b1;
    drive8(1'b1, 1'b0, 8'h12, 8'h34, 1'b1);
    rst16 = 1'b1; ce16 = 1'b1; vld16 = 1'b0; sub16 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;

    step();
    step();
    expect8("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst8 = 1'b0;
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    single8("add_ovf",    1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    single8("sub_neg",    1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    single8("sub_ovf",    1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    single8("slice_cry",  1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    single8("wrap",       1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    single8("cin_wrap",   1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    single8("sub_borrow", 1'b1, 8'h10, 8'h03, 1'b0, 8'h0C, 1'b1, 1'b0);

    // Back-to-back stream with one bubble after the second op.
    drive8(1'b1, 1'b0, 8'h01, 8'h02, 1'b0); step();
    drive8(1'b1, 1'b0, 8'h03, 8'h04, 1'b0); step();
    expect8("strm1", 8'h03, 1'b0, 1'b0, 1'b1);
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0); step();
    expect8("strm2", 8'h07, 1'b0, 1'b0, 1'b1);
    drive8(1'b1, 1'b0, 8'hF0, 8'h10, 1'b0); step();
    check("strm_bubble.valid", 32'(vo8), 32'd0);
    drive8(1'b1, 1'b0, 8'h80, 8'h80, 1'b0); step();
    expect8("strm3", 8'h00, 1'b1, 1'b0, 1'b1);
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0); step();
    expect8("strm4", 8'h00, 1'b1, 1'b1, 1'b1);
    step();
    check("strm_end.valid", 32'(vo8), 32'd0);

    // Clock-enable freeze with one result showing and one op in flight.
    drive8(1'b1, 1'b0, 8'h11, 8'h22, 1'b0); step();
    drive8(1'b1, 1'b0, 8'h40, 8'h05, 1'b0); step();
    expect8("ce_pre", 8'h33, 1'b0, 1'b0, 1'b1);
    ce8 = 1'b0;
    drive8(1'b1, 1'b1, 8'hAA, 8'h55, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      expect8("ce_hold", 8'h33, 1'b0, 1'b0, 1'b1);
    end
    ce8 = 1'b1;
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0); step();
    expect8("ce_resume", 8'h45, 1'b0, 1'b0, 1'b1);
    step();
    expect8("ce_drain", 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset with ops in flight, CE low to show reset takes priority.
    drive8(1'b1, 1'b0, 8'h01, 8'h01, 1'b0); step();
    drive8(1'b1, 1'b0, 8'h02, 8'h02, 1'b0); step();
    expect8("rst_pre", 8'h02, 1'b0, 1'b0, 1'b1);
    rst8 = 1'b1; ce8 = 1'b0;
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0); step();
    expect8("rst_flush", 8'h00, 1'b0, 1'b0, 1'b0);
    rst8 = 1'b0; ce8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      expect8("rst_after", 8'h00, 1'b0, 1'b0, 1'b0);
    end

    // Random stream on the 16-bit, 4-stage instance.
    step();
    rst16 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_o[i] = '0; m_c[i] = 1'b0; m_v[i] = 1'b0; m_vld[i] = 1'b0;
    end
    ops = 0;
    while (ops < 10000) begin
      ce16  = ($urandom_range(0, 4) != 0);
      vld16 = ($urandom_range(0, 3) != 0);
      sub16 = $urandom_range(0, 1);
      cin16 = $urandom_range(0, 1);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      if (ce16 && vld16) ops++;
      bb   = sub16 ? ~b16 : b16;
      full = {1'b0, a16} + {1'b0, bb} + {16'd0, cin16};
      step();
      if (ce16) begin
        for (int i = 3; i > 0; i--) begin
          m_o[i] = m_o[i-1]; m_c[i] = m_c[i-1]; m_v[i] = m_v[i-1]; m_vld[i] = m_vld[i-1];
        end
        m_o[0]   = full[15:0];
        m_c[0]   = full[16];
        m_v[0]   = (a16[15] == bb[15]) && (full[15] != a16[15]);
        m_vld[0] = vld16;
      end
      check("rnd.valid", 32'(vo16), 32'(m_vld[3]));
      if (m_vld[3]) begin
        check("rnd.o",    32'(o16),    32'(m_o[3]));
        check("rnd.cout", 32'(cout16), 32'(m_c[3]));
        check("rnd.v",    32'(v16),    32'(m_v[3]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
